// File: rtl/mux_21.sv
// Two-input multiplexer: combinational out plus registered out_q/sel_q shadow copies.
// Optional saturating select-switch counter enabled by defining MUX21_SWITCH_CNT_EN.
module mux_21 #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_q,
    output logic [CNT_W-1:0] switch_cnt
);

    // Conditional operator keeps the bitwise a/b merge when sel is unknown.
    assign out = (sel == 1'b0) ? a : b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            sel_q <= 1'b0;
        end else begin
            out_q <= out;
            sel_q <= sel;
        end
    end

`ifdef MUX21_SWITCH_CNT_EN
    logic [CNT_W-1:0] cnt;

    // sel_q resets to 0, so a high sel on the first edge after reset counts as a switch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if ((sel != sel_q) && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign switch_cnt = cnt;
`else
    assign switch_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_21.sv
// Directed bench for mux_21: combinational vector table, registered path,
// asynchronous reset and saturating switch counter (CNT_W=2).
module tb_mux_21;

    logic       clk;
    logic       rst_n;
    logic [7:0] a, b;
    logic       sel;
    logic [7:0] out, out_q;
    logic       sel_q;
    logic [1:0] switch_cnt;

    logic       a1, b1, sel1, out1, out_q1, sel_q1;
    logic [7:0] cnt1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       narrow;
        logic [7:0] a;
        logic [7:0] b;
        logic       sel;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    mux_21 #(.WIDTH(8), .CNT_W(2)) dut (
        .out(out), .a(a), .b(b), .sel(sel), .clk(clk), .rst_n(rst_n),
        .out_q(out_q), .sel_q(sel_q), .switch_cnt(switch_cnt)
    );

    // Clock and reset held static: the combinational path must not care.
    mux_21 #(.WIDTH(1), .CNT_W(8)) dut1 (
        .out(out1), .a(a1), .b(b1), .sel(sel1), .clk(1'b0), .rst_n(1'b0),
        .out_q(out_q1), .sel_q(sel_q1), .switch_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic cnt_on;
    int   exp_cnt;

    initial begin
`ifdef MUX21_SWITCH_CNT_EN
        cnt_on = 1'b1;
`else
        cnt_on = 1'b0;
`endif
        vecs[0] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'h00};
        vecs[2] = '{1'b1, 8'h00, 8'h01, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 8'h00, 8'h01, 1'b1, 8'h01};
        vecs[4] = '{1'b1, 8'h01, 8'h00, 1'b0, 8'h01};
        vecs[5] = '{1'b1, 8'h01, 8'h00, 1'b1, 8'h00};
        vecs[6] = '{1'b1, 8'h01, 8'h01, 1'b0, 8'h01};
        vecs[7] = '{1'b1, 8'h01, 8'h01, 1'b1, 8'h01};
        vecs[8] = '{1'b0, 8'hA5, 8'h3C, 1'b0, 8'hA5};
        vecs[9] = '{1'b0, 8'hA5, 8'h3C, 1'b1, 8'h3C};

        rst_n = 1'b1;
        a = 8'h00; b = 8'h00; sel = 1'b0;
        a1 = 1'b0; b1 = 1'b0; sel1 = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_out_q", 32'(out_q), 32'h00);
        check("reset_sel_q", 32'(sel_q), 32'h0);
        check("reset_cnt",   32'(switch_cnt), 32'h0);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].narrow) begin
                a1 = vecs[i].a[0]; b1 = vecs[i].b[0]; sel1 = vecs[i].sel;
                #10;
                check($sformatf("comb_w1_%0d", i), 32'(out1), 32'(vecs[i].exp[0]));
            end else begin
                a = vecs[i].a; b = vecs[i].b; sel = vecs[i].sel;
                #0;
                check($sformatf("comb_w8_%0d", i), 32'(out), 32'(vecs[i].exp));
                #10;
            end
        end

        // Registered path
        @(negedge clk);
        rst_n = 1'b1; a = 8'h01; b = 8'h00; sel = 1'b0;
        tick();
        check("reg0_out_q", 32'(out_q), 32'h01);
        check("reg0_sel_q", 32'(sel_q), 32'h0);
        check("reg0_cnt",   32'(switch_cnt), 32'h0);
        sel = 1'b1;
        tick();
        check("reg1_out_q", 32'(out_q), 32'h00);
        check("reg1_sel_q", 32'(sel_q), 32'h1);
        check("reg1_cnt",   32'(switch_cnt), cnt_on ? 32'h1 : 32'h0);
        sel = 1'b0;
        tick();
        check("reg2_out_q", 32'(out_q), 32'h01);
        check("reg2_cnt",   32'(switch_cnt), cnt_on ? 32'h2 : 32'h0);

        // Asynchronous reset between edges
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_out_q", 32'(out_q), 32'h00);
        check("arst_sel_q", 32'(sel_q), 32'h0);
        check("arst_cnt",   32'(switch_cnt), 32'h0);
        a = 8'h77; b = 8'h11; sel = 1'b1;
        #1;
        check("arst_out_sel1", 32'(out), 32'h11);
        sel = 1'b0;
        #1;
        check("arst_out_sel0", 32'(out), 32'h77);

        // Saturating counter
        @(negedge clk);
        rst_n = 1'b1; a = 8'hA5; b = 8'h3C; sel = 1'b0;
        tick();
        check("cnt_start", 32'(switch_cnt), 32'h0);
        check("cnt_start_out_q", 32'(out_q), 32'hA5);
        for (int i = 0; i < 5; i++) begin
            sel = ~sel;
            tick();
            exp_cnt = cnt_on ? ((i + 1 > 3) ? 3 : i + 1) : 0;
            check($sformatf("tog%0d_cnt", i), 32'(switch_cnt), 32'(exp_cnt));
            check($sformatf("tog%0d_out_q", i), 32'(out_q), sel ? 32'h3C : 32'hA5);
            check($sformatf("tog%0d_sel_q", i), 32'(sel_q), 32'(sel));
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold%0d_cnt", i), 32'(switch_cnt), cnt_on ? 32'h3 : 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_21.md
# mux_21

Two-input, one-select multiplexer with a purely combinational primary output and a registered shadow copy for downstream synchronous logic. It sits in the combinational-primitives library. Existing four-port positional instantiations must keep working unchanged. Sequential additions give timing-closed consumers a registered select result and optional select-switch statistics.

## Interface
Parameters:
- WIDTH, 1: bit width of a, b, out, out_q.
- CNT_W, 8: width of switch_cnt (compiled only with MUX21_SWITCH_CNT_EN).

Ports (listed clock/reset first; RTL declaration order is out, a, b, sel, clk, rst_n, out_q, sel_q, switch_cnt so that positional instantiation (out, a, b, sel) binds correctly):
- clk  input  1  single clock; all registers rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- out  output  WIDTH  combinational mux result.
- a  input  WIDTH  data input selected when sel=0.
- b  input  WIDTH  data input selected when sel=1.
- sel  input  1  select.
- out_q  output  WIDTH  registered out.
- sel_q  output  1  registered sel.
- switch_cnt  output  CNT_W  count of sel transitions (macro-dependent).

## Operation
- out = (sel == 0) ? a : b, continuously; no dependence on clk or rst_n.
- out must be correct with clk/rst_n unconnected (four-port instantiation); out must never be X when a, b, sel are known.
- sel = X/Z: out = a where a == b bitwise, else X per bit (natural ?: semantics).
- out_q captures out each rising clk edge; sel_q captures sel.
- Switch counter (macro on): on each rising edge with rst_n=1, if sel != sel_q then switch_cnt increments by 1, saturating at 2^CNT_W-1 (no wrap).
- First edge after reset: sel_q reset value is 0, so sel=1 on the first edge counts as one switch.

## Timing
- out: zero-cycle combinational latency from a, b, sel.
- out_q, sel_q: one-cycle latency; value at edge N reflects inputs sampled at edge N.
- Reset: rst_n low asynchronously forces out_q=0, sel_q=0, switch_cnt=0 immediately, independent of clk; held while low.
- Reset deassertion: registers resume capture on the first rising edge with rst_n=1.
- Reset mid-operation: counter clears; out unaffected.
- Simultaneous sel change and clock edge: sampled value is the pre-edge value (standard setup).

## Configuration
- MUX21_SWITCH_CNT_EN defined: switch_cnt port and saturating counter present as above.
- Not defined: switch_cnt port is still declared and tied to constant 0; no counter logic synthesized. out, out_q, sel_q are identical in both builds.

## Test plan
- Exhaustive WIDTH=1, clk/rst_n unconnected: {a,b,sel}=0..7, 10 time units each -> out = 0,0,0,1,1,0,1,1; any mismatch fails.
- WIDTH=8, a=8'hA5, b=8'h3C: sel=0 -> out=8'hA5; sel=1 -> out=8'h3C, zero delay.
- Registered path: rst_n=1, a=1, b=0, sel=0 -> out_q=1 one edge later; sel=1 -> out_q=0 and sel_q=1 after the next edge.
- Async reset: after out_q=1, drive rst_n=0 between edges -> out_q=0, sel_q=0, switch_cnt=0 immediately with no clock edge; out still tracks a/b/sel.
- Counter (macro on, CNT_W=2): toggle sel every cycle for 5 cycles -> switch_cnt 1,2,3,3,3 (saturates); hold sel constant -> unchanged.
- Macro off: same toggling -> switch_cnt stays 0; out, out_q identical to macro-on run.
